alu_unit: RTL and testbench
===========================

# alu_unit

Integer execution unit for the out-of-order RISC-V core. It accepts one ALU-class instruction per cycle from the ALU reservation station. Those are the orders the shared order-classifier flags as calculation ops: LUI, AUIPC, R-type and I-type arithmetic/logic/shift. It computes the 32-bit result in one registered stage and queues it in a small result FIFO. It then broadcasts the result on the common data bus (CDB) when the CDB arbiter grants it.

## Interface
- `ROB_W`, default 4: ROB tag width.
- `DEPTH`, default 4: result FIFO entries (power of two, ≥2).

- `clk_in`  in  1  clock.
- `rst_in`  in  1  asynchronous reset, active-high.
- `rdy_in`  in  1  global enable; when low, all state holds.
- `clear_in`  in  1  misprediction flush.
- `in_valid`  in  1  RS presents an instruction.
- `in_ready`  out  1  unit accepts this cycle.
- `in_order`  in  6  order code from the shared defines.
- `in_v1`  in  32  rs1 value.
- `in_v2`  in  32  rs2 value.
- `in_imm`  in  32  sign-extended immediate; for LUI/AUIPC it is already shifted by 12.
- `in_pc`  in  32  instruction PC.
- `in_rob`  in  ROB_W  destination ROB tag.
- `cdb_valid`  out  1  result available.
- `cdb_rob`  out  ROB_W  tag of the head result.
- `cdb_value`  out  32  value of the head result.
- `cdb_grant`  in  1  arbiter consumes the head this cycle.

## Operation
- Accept occurs when `in_valid && in_ready && rdy_in && !clear_in`. The order, operands, pc and tag are registered into stage S1, and `s1_valid` is set.
- Result is computed combinationally from S1:
  - LUI → imm.
  - AUIPC → pc+imm.
  - ADD/SUB/XOR/OR/AND → operation on v1 and v2; ADDI/XORI/ORI/ANDI → same operation on v1 and imm.
  - SLT/SLTI → signed compare, result 1 or 0.
  - SLTU/SLTIU → unsigned compare, result 1 or 0.
  - SLL/SRL/SRA use v2[4:0] as shift amount; SLLI/SRLI/SRAI use imm[4:0]. SRA/SRAI are arithmetic shifts.
  - All arithmetic is modulo 2^32; overflow is ignored.
  - Any non-calculation order yields value 0. Issuing one is an RS protocol error, but the unit still retires it.
- On each enabled edge with `s1_valid`, the computed {tag, value} is pushed into the FIFO and S1 empties, unless a new accept refills it.
- `in_ready = (count + s1_valid) < DEPTH`. Pop is given no credit, so ready is purely registered state. This guarantees S1 never blocks on a full FIFO.
- `cdb_valid = (count != 0)`; `cdb_rob`/`cdb_value` show the FIFO head.
- Pop occurs when `cdb_valid && cdb_grant && rdy_in`. Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- `clear_in` (sampled at an edge while `rdy_in` is high) empties S1 and the FIFO: count, pointers and `s1_valid` go to 0. Any same-cycle accept, push or pop is discarded.
- A grant with `cdb_valid` low is ignored.
- While `rdy_in` is low, no accept, push or pop takes effect, and outputs hold their values.

## Timing
- Reset values: `in_ready`=1, `cdb_valid`=0, `cdb_rob`=0, `cdb_value`=0, count=0, `s1_valid`=0. FIFO storage is also reset to 0.
- Latency: accept at edge N → result pushed at edge N+1 → `cdb_valid` high after edge N+1, with the value visible in cycle N+1 at the earliest.
- Throughput: one instruction per cycle sustained while grant is held high.
- Results leave in issue order.
- Reset asserted mid-operation drops all in-flight work immediately, without waiting for a clock edge.

## Structure
- Order codes (`LUI`…`SRAI`, 6-bit) come from the shared defines file. No new encodings are added; the ALU decode uses the same macros as the classifier.
- Put the combinational datapath in a sub-module `alu_core` (order, v1, v2, imm, pc → value), so it can be unit-tested alone.
- The FIFO is inline in `alu_unit`.

## Test plan
- Reset: hold `rst_in`=1 → `in_ready`=1, `cdb_valid`=0, `cdb_value`=0; release, then issue ADD v1=5, v2=7, tag 3 → one cycle later `cdb_valid`=1, rob=3, value=12.
- Arithmetic corners:
  - SUB 0-1 → 0xFFFFFFFF.
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU with the same operands → 0.
  - SRA 0x80000000 by v2=0x21 → 0xC0000000 (uses low 5 bits, i.e. shift 1).
  - AUIPC pc=0x1000, imm=0x2000 → 0x3000.
- Backpressure: grant=0, issue 5 back-to-back → `in_ready` drops after 4 accepted (count+s1=4); raise grant → 4 results in issue order with correct tags, then ready returns.
- Simultaneous push/pop: grant=1 continuously with 10 back-to-back issues → `in_ready` never drops, one result per cycle, count ≤ 1.
- Flush: 3 results queued plus 1 in S1, assert `clear_in` together with grant and a new `in_valid` → next cycle `cdb_valid`=0, count=0, and no result from the flushed or same-cycle accept ever appears.
- Stall: drop `rdy_in` for 3 cycles while `cdb_valid`=1 and grant=1 → outputs hold, no pop; after `rdy_in` returns, the head pops once.

Source files
------------

// File: rtl/alu_unit_pkg.sv
// Shared order codes and types for the ALU execution unit.
// Codes mirror the core-wide order defines used by the classifier.
package alu_unit_pkg;

  typedef logic [5:0] order_t;

  localparam order_t ORD_LUI   = 6'd1;
  localparam order_t ORD_AUIPC = 6'd2;
  localparam order_t ORD_ADD   = 6'd3;
  localparam order_t ORD_SUB   = 6'd4;
  localparam order_t ORD_XOR   = 6'd5;
  localparam order_t ORD_OR    = 6'd6;
  localparam order_t ORD_AND   = 6'd7;
  localparam order_t ORD_SLT   = 6'd8;
  localparam order_t ORD_SLTU  = 6'd9;
  localparam order_t ORD_SLL   = 6'd10;
  localparam order_t ORD_SRL   = 6'd11;
  localparam order_t ORD_SRA   = 6'd12;
  localparam order_t ORD_ADDI  = 6'd13;
  localparam order_t ORD_XORI  = 6'd14;
  localparam order_t ORD_ORI   = 6'd15;
  localparam order_t ORD_ANDI  = 6'd16;
  localparam order_t ORD_SLTI  = 6'd17;
  localparam order_t ORD_SLTIU = 6'd18;
  localparam order_t ORD_SLLI  = 6'd19;
  localparam order_t ORD_SRLI  = 6'd20;
  localparam order_t ORD_SRAI  = 6'd21;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: order and operands in, 32-bit value out.
// Non-calculation orders produce zero.
module alu_core
  import alu_unit_pkg::*;
(
  input  logic [5:0]  order,
  input  logic [31:0] v1,
  input  logic [31:0] v2,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic [31:0] value
);

  always_comb begin
    value = '0;
    unique case (order)
      ORD_LUI:   value = imm;
      ORD_AUIPC: value = pc + imm;
      ORD_ADD:   value = v1 + v2;
      ORD_ADDI:  value = v1 + imm;
      ORD_SUB:   value = v1 - v2;
      ORD_XOR:   value = v1 ^ v2;
      ORD_XORI:  value = v1 ^ imm;
      ORD_OR:    value = v1 | v2;
      ORD_ORI:   value = v1 | imm;
      ORD_AND:   value = v1 & v2;
      ORD_ANDI:  value = v1 & imm;
      ORD_SLT:   value = {31'd0, $signed(v1) < $signed(v2)};
      ORD_SLTI:  value = {31'd0, $signed(v1) < $signed(imm)};
      ORD_SLTU:  value = {31'd0, v1 < v2};
      ORD_SLTIU: value = {31'd0, v1 < imm};
      ORD_SLL:   value = v1 << v2[4:0];
      ORD_SLLI:  value = v1 << imm[4:0];
      ORD_SRL:   value = v1 >> v2[4:0];
      ORD_SRLI:  value = v1 >> imm[4:0];
      ORD_SRA:   value = $unsigned($signed(v1) >>> v2[4:0]);
      ORD_SRAI:  value = $unsigned($signed(v1) >>> imm[4:0]);
      default:   value = '0;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// ALU execution unit: one registered compute stage feeding a result
// FIFO that drains onto the CDB under arbiter grant.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int ROB_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_order,
  input  logic [31:0]      in_v1,
  input  logic [31:0]      in_v2,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_pc,
  input  logic [ROB_W-1:0] in_rob,
  output logic             cdb_valid,
  output logic [ROB_W-1:0] cdb_rob,
  output logic [31:0]      cdb_value,
  input  logic             cdb_grant
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic             s1_valid_q, s1_valid_d;
  order_t           s1_order_q, s1_order_d;
  logic [31:0]      s1_v1_q, s1_v1_d;
  logic [31:0]      s1_v2_q, s1_v2_d;
  logic [31:0]      s1_imm_q, s1_imm_d;
  logic [31:0]      s1_pc_q, s1_pc_d;
  logic [ROB_W-1:0] s1_rob_q, s1_rob_d;

  logic [ROB_W-1:0] rob_mem_q [DEPTH];
  logic [ROB_W-1:0] rob_mem_d [DEPTH];
  logic [31:0]      val_mem_q [DEPTH];
  logic [31:0]      val_mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [31:0]      s1_value;
  logic [CW:0]      occ;
  logic             accept, push, pop;

  alu_core u_core (
    .order (s1_order_q),
    .v1    (s1_v1_q),
    .v2    (s1_v2_q),
    .imm   (s1_imm_q),
    .pc    (s1_pc_q),
    .value (s1_value)
  );

  // Ready ignores a same-cycle pop so it depends only on flops.
  assign occ       = {1'b0, count_q} + (CW+1)'(s1_valid_q);
  assign in_ready  = occ < (CW+1)'(DEPTH);
  assign cdb_valid = count_q != '0;
  assign cdb_rob   = rob_mem_q[rptr_q];
  assign cdb_value = val_mem_q[rptr_q];

  assign accept = in_valid && in_ready && rdy_in && !clear_in;
  assign push   = s1_valid_q && rdy_in && !clear_in;
  assign pop    = cdb_valid && cdb_grant && rdy_in && !clear_in;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_order_d = s1_order_q;
    s1_v1_d    = s1_v1_q;
    s1_v2_d    = s1_v2_q;
    s1_imm_d   = s1_imm_q;
    s1_pc_d    = s1_pc_q;
    s1_rob_d   = s1_rob_q;
    rob_mem_d  = rob_mem_q;
    val_mem_d  = val_mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    if (rdy_in && clear_in) begin
      s1_valid_d = 1'b0;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
    end else if (rdy_in) begin
      if (push) begin
        rob_mem_d[wptr_q] = s1_rob_q;
        val_mem_d[wptr_q] = s1_value;
        wptr_d            = wptr_q + PW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      s1_valid_d = accept;
      if (accept) begin
        s1_order_d = in_order;
        s1_v1_d    = in_v1;
        s1_v2_d    = in_v2;
        s1_imm_d   = in_imm;
        s1_pc_d    = in_pc;
        s1_rob_d   = in_rob;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid_q <= 1'b0;
      s1_order_q <= '0;
      s1_v1_q    <= '0;
      s1_v2_q    <= '0;
      s1_imm_q   <= '0;
      s1_pc_q    <= '0;
      s1_rob_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_mem_q[i] <= '0;
        val_mem_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_order_q <= s1_order_d;
      s1_v1_q    <= s1_v1_d;
      s1_v2_q    <= s1_v2_d;
      s1_imm_q   <= s1_imm_d;
      s1_pc_q    <= s1_pc_d;
      s1_rob_q   <= s1_rob_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rob_mem_q  <= rob_mem_d;
      val_mem_q  <= val_mem_d;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Bench for alu_unit: directed corners plus random traffic checked
// against an in-order scoreboard of accepted instructions.
module tb_alu_unit;
  import alu_unit_pkg::*;

  localparam int ROB_W = 4;
  localparam int DEPTH = 4;

  logic             clk_in = 1'b0;
  logic             rst_in, rdy_in, clear_in;
  logic             in_valid, in_ready;
  logic [5:0]       in_order;
  logic [31:0]      in_v1, in_v2, in_imm, in_pc;
  logic [ROB_W-1:0] in_rob;
  logic             cdb_valid, cdb_grant;
  logic [ROB_W-1:0] cdb_rob;
  logic [31:0]      cdb_value;

  always #5 clk_in = ~clk_in;

  alu_unit #(.ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .clear_in  (clear_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_order  (in_order),
    .in_v1     (in_v1),
    .in_v2     (in_v2),
    .in_imm    (in_imm),
    .in_pc     (in_pc),
    .in_rob    (in_rob),
    .cdb_valid (cdb_valid),
    .cdb_rob   (cdb_rob),
    .cdb_value (cdb_value),
    .cdb_grant (cdb_grant)
  );

  typedef struct {
    logic [ROB_W-1:0] rob;
    logic [31:0]      val;
    int               k;
  } item_t;

  item_t q[$];
  int    en_cyc = 0;
  int    total = 0;
  int    bad = 0;

  order_t ops [0:22] = '{ORD_LUI, ORD_AUIPC, ORD_ADD, ORD_SUB, ORD_XOR,
    ORD_OR, ORD_AND, ORD_SLT, ORD_SLTU, ORD_SLL, ORD_SRL, ORD_SRA,
    ORD_ADDI, ORD_XORI, ORD_ORI, ORD_ANDI, ORD_SLTI, ORD_SLTIU,
    ORD_SLLI, ORD_SRLI, ORD_SRAI, 6'd0, 6'd63};

  function automatic logic [31:0] ref_alu(logic [5:0] o, logic [31:0] a,
    logic [31:0] b, logic [31:0] imm, logic [31:0] pc);
    logic [31:0] r;
    logic [4:0]  sh;
    r = (o inside {ORD_ADDI, ORD_XORI, ORD_ORI, ORD_ANDI, ORD_SLTI,
      ORD_SLTIU, ORD_SLLI, ORD_SRLI, ORD_SRAI}) ? imm : b;
    sh = r[4:0];
    case (o)
      ORD_LUI:             return imm;
      ORD_AUIPC:           return pc + imm;
      ORD_ADD, ORD_ADDI:   return a + r;
      ORD_SUB:             return a - r;
      ORD_XOR, ORD_XORI:   return a ^ r;
      ORD_OR, ORD_ORI:     return a | r;
      ORD_AND, ORD_ANDI:   return a & r;
      ORD_SLT, ORD_SLTI:
        return ((a ^ 32'h8000_0000) < (r ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      ORD_SLTU, ORD_SLTIU: return (a < r) ? 32'd1 : 32'd0;
      ORD_SLL, ORD_SLLI:   return a << sh;
      ORD_SRL, ORD_SRLI:   return a >> sh;
      ORD_SRA, ORD_SRAI:
        return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      default:             return 32'd0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check outputs against the scoreboard, then advance one clock.
  task automatic cycle();
    item_t it;
    logic  exp_rdy, exp_v, acc, pp, en, clr;
    exp_rdy = q.size() < DEPTH;
    exp_v   = (q.size() > 0) && (q[0].k < en_cyc);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("cdb_valid", 32'(cdb_valid), 32'(exp_v));
    if (exp_v) begin
      chk("cdb_rob", 32'(cdb_rob), 32'(q[0].rob));
      chk("cdb_value", cdb_value, q[0].val);
    end
    en     = rdy_in;
    clr    = clear_in;
    acc    = in_valid && exp_rdy && rdy_in && !clear_in;
    pp     = exp_v && cdb_grant && rdy_in && !clear_in;
    it.rob = in_rob;
    it.val = ref_alu(in_order, in_v1, in_v2, in_imm, in_pc);
    it.k   = 0;
    @(posedge clk_in);
    #1;
    if (en) begin
      en_cyc++;
      if (clr) begin
        q.delete();
      end else begin
        if (pp) void'(q.pop_front());
        if (acc) begin
          it.k = en_cyc;
          q.push_back(it);
        end
      end
    end
  endtask

  task automatic issue(logic [5:0] o, logic [31:0] a, logic [31:0] b,
    logic [31:0] imm, logic [31:0] pc, logic [ROB_W-1:0] rob);
    in_valid = 1'b1;
    in_order = o;
    in_v1    = a;
    in_v2    = b;
    in_imm   = imm;
    in_pc    = pc;
    in_rob   = rob;
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [31:0] held;
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    clear_in  = 1'b0;
    in_valid  = 1'b0;
    in_order  = '0;
    in_v1     = '0;
    in_v2     = '0;
    in_imm    = '0;
    in_pc     = '0;
    in_rob    = '0;
    cdb_grant = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    chk("rst_cdb_value", cdb_value, 32'd0);
    chk("rst_cdb_rob", 32'(cdb_rob), 32'd0);
    rst_in = 1'b0;
    @(posedge clk_in);
    #1;

    // First result: ADD 5+7, tag 3.
    issue(ORD_ADD, 32'd5, 32'd7, 32'd0, 32'd0, 4'd3);
    cycle();
    idle(1);
    chk("add_valid", 32'(cdb_valid), 32'd1);
    chk("add_rob", 32'(cdb_rob), 32'd3);
    chk("add_value", cdb_value, 32'd12);
    cdb_grant = 1'b1;
    idle(2);

    // Arithmetic corners.
    issue(ORD_SUB, 32'd0, 32'd1, 32'd0, 32'd0, 4'd1);
    cycle();
    issue(ORD_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd2);
    cycle();
    issue(ORD_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd4);
    cycle();
    issue(ORD_SRA, 32'h8000_0000, 32'h21, 32'd0, 32'd0, 4'd5);
    cycle();
    issue(ORD_AUIPC, 32'd0, 32'd0, 32'h2000, 32'h1000, 4'd6);
    cycle();
    issue(ORD_SRAI, 32'hF000_0000, 32'd0, 32'd4, 32'd0, 4'd7);
    cycle();
    idle(3);

    // Backpressure: no grant, five back-to-back issues.
    cdb_grant = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(ORD_ADDI, 32'(i * 100), 32'd0, 32'd1, 32'd0, 4'(8 + i));
      cycle();
    end
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    cdb_grant = 1'b1;
    idle(6);
    chk("bp_ready_back", 32'(in_ready), 32'd1);

    // Sustained throughput with grant held.
    for (int i = 0; i < 10; i++) begin
      issue(ORD_XOR, 32'(i), 32'h5A5A_0000, 32'd0, 32'd0, 4'(i));
      cycle();
    end
    idle(3);

    // Flush with 3 queued, 1 in S1, grant and a new issue pending.
    cdb_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(ORD_OR, 32'(i), 32'h100, 32'd0, 32'd0, 4'(i + 1));
      cycle();
    end
    cdb_grant = 1'b1;
    clear_in  = 1'b1;
    issue(ORD_LUI, 32'd0, 32'd0, 32'hABCD_E000, 32'd0, 4'd15);
    cycle();
    clear_in = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(cdb_valid), 32'd0);
    idle(4);

    // Stall: rdy_in low while a head is granted.
    cdb_grant = 1'b0;
    issue(ORD_ANDI, 32'hFFFF_00FF, 32'd0, 32'h0F0F_0F0F, 32'd0, 4'd9);
    cycle();
    issue(ORD_SLL, 32'd1, 32'd31, 32'd0, 32'd0, 4'd10);
    cycle();
    idle(1);
    held      = cdb_value;
    cdb_grant = 1'b1;
    rdy_in    = 1'b0;
    idle(3);
    chk("stall_hold", cdb_value, held);
    rdy_in = 1'b1;
    idle(3);

    // Asynchronous reset in the middle of work.
    cdb_grant = 1'b0;
    issue(ORD_ADD, 32'd1, 32'd2, 32'd0, 32'd0, 4'd1);
    cycle();
    cycle();
    in_valid = 1'b0;
    #3;
    rst_in = 1'b1;
    #1;
    chk("arst_valid", 32'(cdb_valid), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_value", cdb_value, 32'd0);
    rst_in = 1'b0;
    q.delete();
    idle(2);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      rdy_in    = ($urandom % 8) != 0;
      cdb_grant = ($urandom % 3) != 0;
      clear_in  = ($urandom % 50) == 0;
      in_valid  = ($urandom % 4) != 0;
      in_order  = ops[$urandom % 23];
      in_v1     = ($urandom % 2) ? $urandom : 32'($urandom % 8);
      in_v2     = $urandom;
      in_imm    = $urandom;
      in_pc     = $urandom;
      in_rob    = ROB_W'($urandom);
      cycle();
    end
    rdy_in    = 1'b1;
    clear_in  = 1'b0;
    cdb_grant = 1'b1;
    idle(8);
    chk("drain_empty", 32'(cdb_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
